sub_bytes_iter: RTL and testbench

Iterative forward AES-128 SubBytes engine for the encryption datapath, the counterpart to the existing inverse SubBytes stage on the decryption side. It accepts a 128-bit state over a valid/ready handshake and substitutes it `BYTES_PER_CYCLE` bytes per clock through a shared S-box bank. It presents the substituted state over a second valid/ready handshake. It trades the 16-S-box area of a fully parallel stage for `16/BYTES_PER_CYCLE` cycles of latency.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox.sv | 19 +
 rtl/sub_bytes_iter.sv | 113 +++++++++++
 tb/tb_sub_bytes_iter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: FSM state encoding, forward/inverse S-box tables
package aes_pkg;

   localparam int AES_STATE_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } aes_state_e;

   // Entry i lives at bits [2047-8*i -: 8]; rows are 16 consecutive entries.
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return SBOX_FWD[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      return SBOX_INV[2047 - 8*int'(b) -: 8];
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational 8-bit AES S-box lookup
// INV select present only when SUB_BYTES_ITER_INV_EN is defined.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] sbox_in,
`ifdef SUB_BYTES_ITER_INV_EN
   input  logic       INV,
`endif
   output logic [7:0] sbox_out
);

`ifdef SUB_BYTES_ITER_INV_EN
   assign sbox_out = INV ? sbox_inv(sbox_in) : sbox_fwd(sbox_in);
`else
   assign sbox_out = sbox_fwd(sbox_in);
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes, BYTES_PER_CYCLE bytes per clock
// Optional inverse mode via macro SUB_BYTES_ITER_INV_EN (adds INV port).
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [AES_STATE_W-1:0] IN_DATA,
`ifdef SUB_BYTES_ITER_INV_EN
   input  logic                   INV,
`endif
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic [AES_STATE_W-1:0] SB_DATA_OUT,
   output logic                   BUSY
);

   localparam int N     = 16 / BYTES_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
            BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
         $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   aes_state_e             state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [AES_STATE_W-1:0] work_q;
   logic [AES_STATE_W-1:0] work_next;
   logic [7:0]             sb_in  [BYTES_PER_CYCLE];
   logic [7:0]             sb_out [BYTES_PER_CYCLE];
   int                     grp;
`ifdef SUB_BYTES_ITER_INV_EN
   logic                   inv_q;
`endif

   // With N == 1 the counter may sit at 1 in DONE; pin the group so indices stay in range.
   assign grp = (N == 1) ? 0 : int'(cnt_q);

   always_comb begin
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         sb_in[j] = work_q[8*(15 - (grp*BYTES_PER_CYCLE + j)) +: 8];
      end
   end

   always_comb begin
      work_next = work_q;
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         work_next[8*(15 - (grp*BYTES_PER_CYCLE + j)) +: 8] = sb_out[j];
      end
   end

   generate
      for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
         aes_sbox u_sbox (
            .sbox_in  (sb_in[j]),
`ifdef SUB_BYTES_ITER_INV_EN
            .INV      (inv_q),
`endif
            .sbox_out (sb_out[j])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
`ifdef SUB_BYTES_ITER_INV_EN
         inv_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (IN_VALID) begin
                  work_q  <= IN_DATA;
                  cnt_q   <= '0;
                  state_q <= RUN;
`ifdef SUB_BYTES_ITER_INV_EN
                  inv_q   <= INV;
`endif
               end
            end
            RUN: begin
               work_q <= work_next;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(N - 1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (OUT_READY) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign IN_READY    = (state_q == IDLE);
   assign OUT_VALID   = (state_q == DONE);
   assign BUSY        = (state_q != IDLE);
   assign SB_DATA_OUT = work_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb/tb_sub_bytes_iter.sv - directed bench for sub_bytes_iter at BYTES_PER_CYCLE 4, 1, 2, 8, 16
module tb_sub_bytes_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic [127:0] in_data;
   logic         inv;
   logic [4:0]   rdy;
   logic [4:0]   vld;
   logic [4:0]   bsy;
   logic [127:0] dat [5];
   int           tests = 0;
   int           fails = 0;

   always #5 clk = ~clk;

   function automatic int bpc(input int d);
      case (d)
         0: return 4;
         1: return 1;
         2: return 2;
         3: return 8;
         default: return 16;
      endcase
   endfunction

   generate
      for (genvar g = 0; g < 5; g++) begin : g_dut
         sub_bytes_iter #(.BYTES_PER_CYCLE(bpc(g))) u_dut (
            .clk         (clk),
            .rst         (rst),
            .IN_VALID    (in_valid),
            .IN_READY    (rdy[g]),
            .IN_DATA     (in_data),
`ifdef SUB_BYTES_ITER_INV_EN
            .INV         (inv),
`endif
            .OUT_VALID   (vld[g]),
            .OUT_READY   (out_ready),
            .SB_DATA_OUT (dat[g]),
            .BUSY        (bsy[g])
         );
      end
   endgenerate

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // All DUTs idle on entry; accepts one block, checks per-DUT latency, result and drain.
   task automatic run_all(input string tag, input logic [127:0] din, input logic [127:0] exp);
      in_data  = din;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         for (int d = 0; d < 5; d++) begin
            check($sformatf("%s_valid_b%0d_k%0d", tag, bpc(d), k), 128'(vld[d]),
                  128'(k >= 16 / bpc(d)));
         end
      end
      for (int d = 0; d < 5; d++) begin
         check($sformatf("%s_data_b%0d", tag, bpc(d)), dat[d], exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int d = 0; d < 5; d++) begin
         check($sformatf("%s_ready_b%0d", tag, bpc(d)), 128'(rdy[d]), 128'd1);
      end
   endtask

   initial begin
      logic seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      inv       = 1'b0;
      tick();
      tick();
      check("reset_in_ready",  128'(rdy[0]), 128'd1);
      check("reset_out_valid", 128'(vld[0]), 128'd0);
      check("reset_busy",      128'(bsy[0]), 128'd0);
      check("reset_data",      dat[0],       128'd0);
      rst = 1'b0;
      tick();

      run_all("known", 128'h00112233445566778899aabbccddeeff,
              128'h638293c31bfc33f5c4eeacea4bc12816);
      run_all("zeros", {16{8'h00}}, {16{8'h63}});
      run_all("ones",  {16{8'hff}}, {16{8'h16}});

      // Output backpressure on the default instance
      in_data  = {16{8'h53}};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("bp_busy_after_accept", 128'(bsy[0]), 128'd1);
      for (int k = 0; k < 4; k++) tick();
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bp_valid_%0d", k), 128'(vld[0]), 128'd1);
         check($sformatf("bp_data_%0d", k),  dat[0],       {16{8'hed}});
         check($sformatf("bp_ready_%0d", k), 128'(rdy[0]), 128'd0);
         in_valid = (k == 3);
         in_data  = (k == 3) ? {16{8'h01}} : '0;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_ready_after_release", 128'(rdy[0]), 128'd1);
      check("bp_valid_after_release", 128'(vld[0]), 128'd0);
      check("bp_data_not_overwritten", dat[0], {16{8'hed}});
      for (int k = 0; k < 16; k++) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset two cycles after accept
      in_data  = 128'h0123456789abcdef0123456789abcdef;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_in_ready",  128'(rdy[0]), 128'd1);
      check("rst_mid_out_valid", 128'(vld[0]), 128'd0);
      check("rst_mid_busy",      128'(bsy[0]), 128'd0);
      check("rst_mid_data",      dat[0],       128'd0);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (vld[0]) seen = 1'b1;
      end
      check("rst_mid_no_valid_pulse", 128'(seen), 128'd0);

      // Back-to-back blocks on the default instance (N = 4, accepts 6 apart)
      in_data   = {16{8'h53}};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_data = {16{8'h01}};
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 3) check("b2b_first_not_early", 128'(vld[0]), 128'd0);
         if (c == 4) begin
            check("b2b_first_valid", 128'(vld[0]), 128'd1);
            check("b2b_first_data",  dat[0],       {16{8'hed}});
         end
         if (c == 5) check("b2b_idle_gap",    128'(rdy[0]), 128'd1);
         if (c == 6) begin
            check("b2b_second_accept", 128'(bsy[0]), 128'd1);
            in_valid = 1'b0;
         end
         if (c == 9) check("b2b_second_not_early", 128'(vld[0]), 128'd0);
         if (c == 10) begin
            check("b2b_second_valid", 128'(vld[0]), 128'd1);
            check("b2b_second_data",  dat[0],       {16{8'h7c}});
         end
      end
      for (int k = 0; k < 20; k++) tick();
      out_ready = 1'b0;

`ifdef SUB_BYTES_ITER_INV_EN
      inv = 1'b1;
      run_all("inv", 128'h638293c31bfc33f5c4eeacea4bc12816,
              128'h00112233445566778899aabbccddeeff);
      inv = 1'b0;
      run_all("inv_off_zeros", {16{8'h00}}, {16{8'h63}});
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
